// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared sizes, loader state encoding and count decoding for the instruction memory loader
package imem_pkg;
  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_WIDTH  = 16;
  localparam int IMEM_ADDR_W = 6;
  localparam logic [IMEM_ADDR_W:0] IMEM_DEPTH_N = (IMEM_ADDR_W + 1)'(IMEM_DEPTH);

  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CSUM, DONE} loader_state_t;
  typedef logic [15:0] instr_t;

  // A count of zero or anything beyond the array size means "fill the whole array".
  function automatic logic [IMEM_ADDR_W:0] eff_count(input logic [7:0] b);
    logic [IMEM_ADDR_W:0] n;
    n = b[IMEM_ADDR_W:0];
    if (n == '0 || n > IMEM_DEPTH_N) n = IMEM_DEPTH_N;
    return n;
  endfunction
endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x WIDTH instruction storage, synchronous write and clear, combinational read
module imem_array
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [IMEM_ADDR_W-1:0] waddr,
  input  instr_t                 wdata,
  input  logic [IMEM_ADDR_W-1:0] raddr,
  output instr_t                 rdata
);
  instr_t mem_q [IMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < IMEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader FSM filling imem_array; core reads it and is held while loading
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic [IMEM_ADDR_W-1:0] rd_addr,
  output logic [IMEM_WIDTH-1:0]  rd_data,
  output logic                   busy,
  output logic                   cpu_hold,
  output logic                   done,
  output logic [IMEM_ADDR_W-1:0] word_count,
  output logic                   csum_err
);
  loader_state_t          state_q, state_d;
  logic [IMEM_ADDR_W:0]   cnt_q, cnt_d;
  logic [IMEM_ADDR_W:0]   n_q, n_d;
  logic [7:0]             hi_q, hi_d;
  logic                   we;
  logic                   xfer;

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = COUNT;
          cnt_d   = '0;
        end
      end
      COUNT: begin
        if (xfer) begin
          n_d     = eff_count(in_data);
          state_d = HI;
        end
      end
      HI: begin
        if (xfer) begin
          hi_d    = in_data;
          state_d = LO;
        end
      end
      LO: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 < n_q) state_d = HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
          else state_d = CSUM;
`else
          else state_d = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      COUNT, HI, LO, CSUM: in_ready = 1'b1;
      DONE:                done     = 1'b1;
      default:             ;
    endcase
    busy     = in_ready;
    cpu_hold = in_ready;
    we       = (state_q == LO) && in_valid;
  end

  assign word_count = cnt_q[IMEM_ADDR_W-1:0];

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       csum_err_q, csum_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q     <= '0;
      csum_err_q <= 1'b0;
    end else begin
      csum_q     <= csum_d;
      csum_err_q <= csum_err_d;
    end
  end

  // Running XOR covers every data byte; the count byte is excluded.
  always_comb begin
    csum_d     = csum_q;
    csum_err_d = csum_err_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      csum_d     = '0;
      csum_err_d = 1'b0;
    end else if (xfer && (state_q == HI || state_q == LO)) begin
      csum_d = csum_q ^ in_data;
    end else if (xfer && state_q == CSUM) begin
      csum_err_d = (in_data != csum_q);
    end
  end

  assign csum_err = csum_err_q;
`else
  assign csum_err = 1'b0;
`endif

  imem_array u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (cnt_q[IMEM_ADDR_W-1:0]),
    .wdata ({hi_q, in_data}),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader (table loads, random loads, corner sequences)
// Checksum byte is sent and checked when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy, cpu_hold, done, csum_err;
  logic [5:0]  word_count;

  int checks = 0;
  int failures = 0;

  logic [15:0] ref_mem [64];
  logic [7:0]  dbytes [128];

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .cpu_hold(cpu_hold), .done(done), .word_count(word_count), .csum_err(csum_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cnt_byte;
    int         words;
    int         exp_wc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int n_eff(input logic [7:0] b);
    int n;
    n = b % 128;
    return (n == 0 || n > 64) ? 64 : n;
  endfunction

  task automatic idle(input int gapmax);
    in_valid = 1'b0;
    repeat ($urandom_range(0, gapmax)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] cnt, input int nw, input int gapmax,
                         input int mid_start, input bit bad);
    logic [7:0] x;
    x = 8'h00;
    pulse_start();
    idle(gapmax);
    send_byte(cnt);
    for (int i = 0; i < nw; i++) begin
      if (i == mid_start) pulse_start();
      idle(gapmax);
      send_byte(dbytes[2*i]);
      idle(gapmax);
      send_byte(dbytes[2*i+1]);
      ref_mem[i] = {dbytes[2*i], dbytes[2*i+1]};
      x = x ^ dbytes[2*i] ^ dbytes[2*i+1];
      rd_addr = i[5:0];
      #1;
      chk("rd_latency", {16'd0, rd_data}, {16'd0, ref_mem[i]});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    idle(gapmax);
    send_byte(x ^ {7'd0, bad});
`else
    if (bad) x = ~x;
`endif
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rd_addr = i[5:0];
      #1;
      chk(tag, {16'd0, rd_data}, {16'd0, ref_mem[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_done(input string tag, input int wc, input bit err);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy"}, {30'd0, busy, cpu_hold}, 32'd0);
    chk({tag, "_wc"}, {26'd0, word_count}, wc);
    chk({tag, "_csum_err"}, {31'd0, csum_err}, {31'd0, err});
  endtask

  initial begin
    vec_t vecs [6];
    bit   csum_on;
    int   n;
    logic [7:0] cb;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_on = 1'b1;
`else
    csum_on = 1'b0;
`endif
    vecs[0] = '{8'h01, 1, 1};
    vecs[1] = '{8'h82, 2, 2};
    vecs[2] = '{8'h3F, 63, 63};
    vecs[3] = '{8'hC1, 64, 0};
    vecs[4] = '{8'h40, 64, 0};
    vecs[5] = '{8'h7F, 64, 0};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; rd_addr = 6'd0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wc", {26'd0, word_count}, 32'd0);
    chk("rst_csum_err", {31'd0, csum_err}, 32'd0);
    check_mem("rst_mem");

    // 2: three-word example
    dbytes[0] = 8'hE0; dbytes[1] = 8'h03; dbytes[2] = 8'h18;
    dbytes[3] = 8'h42; dbytes[4] = 8'h47; dbytes[5] = 8'h70;
    do_load(8'h03, 3, 0, -1, 1'b0);
    check_done("ex3", 3, 1'b0);
    rd_addr = 6'd1; #1; chk("ex3_mem1", {16'd0, rd_data}, 32'h1842);
    rd_addr = 6'd2; #1; chk("ex3_mem2", {16'd0, rd_data}, 32'h4770);
    rd_addr = 6'd3; #1; chk("ex3_mem3", {16'd0, rd_data}, 32'h0000);
    @(posedge clk); #1;
    chk("ex3_no_accept", {31'd0, in_ready}, 32'd0);

    // table-driven count decoding
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 128; i++) dbytes[i] = 8'($urandom);
      do_load(vecs[v].cnt_byte, vecs[v].words, 0, -1, 1'b0);
      check_done("tbl", vecs[v].exp_wc, 1'b0);
    end
    check_mem("tbl_mem");

    // 3: full load with gaps, count byte 00
    for (int i = 0; i < 128; i++) dbytes[i] = 8'($urandom);
    do_load(8'h00, 64, 3, -1, 1'b0);
    check_done("full", 0, 1'b0);
    check_mem("full_mem");

    // random loads against the reference model
    for (int r = 0; r < 3; r++) begin
      cb = 8'($urandom);
      n = n_eff(cb);
      for (int i = 0; i < 128; i++) dbytes[i] = 8'($urandom);
      do_load(cb, n, 2, -1, 1'b0);
      check_done("rnd", n % 64, 1'b0);
      check_mem("rnd_mem");
    end

    // 4: reset after third data byte of a two-word load
    pulse_start();
    send_byte(8'h02);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0000;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    rd_addr = 6'd0; #1;
    chk("rst_mid_mem0", {16'd0, rd_data}, 32'd0);
    check_mem("rst_mid_mem");

    // 5: start while busy is ignored, then a shorter reload keeps the tail
    for (int i = 0; i < 128; i++) dbytes[i] = 8'($urandom);
    do_load(8'h03, 3, 1, 1, 1'b0);
    check_done("midstart", 3, 1'b0);
    for (int i = 0; i < 128; i++) dbytes[i] = 8'($urandom);
    do_load(8'h01, 1, 1, -1, 1'b0);
    check_done("reload", 1, 1'b0);
    check_mem("reload_mem");

    // 6: checksum good / bad / cleared by next start
    dbytes[0] = 8'h12; dbytes[1] = 8'h34;
    do_load(8'h01, 1, 0, -1, 1'b0);
    check_done("csum_good", 1, 1'b0);
    do_load(8'h01, 1, 0, -1, 1'b1);
    check_done("csum_bad", 1, csum_on);
    rd_addr = 6'd0; #1;
    chk("csum_mem0", {16'd0, rd_data}, 32'h1234);
    do_load(8'h01, 1, 0, -1, 1'b0);
    check_done("csum_clear", 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
